// File: rtl/mlu_pkg.sv
// mlu_pkg: shared types and defaults for the MLU carry engine.
//   mlu_carry_state_t : sequencer states (IDLE, RUN, DONE)
//   mlu_carry_mode_t  : CHAIN (carry ripples across slices) / LANES (per-slice C_IN)
//   MLU_SLICE_W_DEFAULT, MLU_NUM_SLICES_DEFAULT : default geometry
package mlu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mlu_carry_state_t;

  typedef enum logic {
    MLU_CARRY_CHAIN = 1'b0,
    MLU_CARRY_LANES = 1'b1
  } mlu_carry_mode_t;

  localparam int unsigned MLU_SLICE_W_DEFAULT    = 8;
  localparam int unsigned MLU_NUM_SLICES_DEFAULT = 4;

endpackage

// File: rtl/mlu_slice_carry.sv
// mlu_slice_carry: combinational ripple-carry over one SLICE_W-bit slice.
//   CIN    : carry into bit 0 of the slice
//   P, G   : per-bit propagate / generate
//   CARRYS : carry out of each bit
//   COUT   : carry out of the top bit
module mlu_slice_carry #(
  parameter int unsigned SLICE_W = mlu_pkg::MLU_SLICE_W_DEFAULT
) (
  input  logic               CIN,
  input  logic [SLICE_W-1:0] P,
  input  logic [SLICE_W-1:0] G,
  output logic [SLICE_W-1:0] CARRYS,
  output logic               COUT
);

  logic c;

  always_comb begin
    CARRYS = '0;
    c      = CIN;
    for (int unsigned j = 0; j < SLICE_W; j++) begin
      c         = (c & P[j]) | G[j];
      CARRYS[j] = c;
    end
    COUT = c;
  end

endmodule

// File: rtl/mlu_carry_seq.sv
// mlu_carry_seq: multi-cycle carry engine, one SLICE_W slice resolved per clock.
//   CLK, N_RST   : clock, synchronous active-low reset
//   START        : request, sampled in IDLE or DONE
//   MODE, C_IN   : CHAIN/LANES select and carry-in, latched at accept
//   P, G         : W-bit propagate/generate, latched at accept
//   CARRYS, C_OUT: per-bit carries and top carry, valid from DONE until next accept
//   BUSY, DONE   : RUN indicator, one-cycle completion pulse
//   GP, GG       : per-slice group propagate/generate
// Build options:
//   MLU_CARRY_GROUP_PG_EN : register GP/GG per slice; otherwise they are tied to 0
//   FORMAL                : assert CARRYS against a full-width ripple reference at DONE
module mlu_carry_seq #(
  parameter  int unsigned SLICE_W    = mlu_pkg::MLU_SLICE_W_DEFAULT,
  parameter  int unsigned NUM_SLICES = mlu_pkg::MLU_NUM_SLICES_DEFAULT,
  localparam int unsigned W          = SLICE_W * NUM_SLICES
) (
  input  logic                  CLK,
  input  logic                  N_RST,
  input  logic                  START,
  input  logic                  MODE,
  input  logic                  C_IN,
  input  logic [W-1:0]          P,
  input  logic [W-1:0]          G,
  output logic [W-1:0]          CARRYS,
  output logic                  C_OUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [NUM_SLICES-1:0] GP,
  output logic [NUM_SLICES-1:0] GG
);

  import mlu_pkg::*;

  localparam int unsigned   IDX_W    = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  mlu_carry_state_t state, state_nxt;
  logic             accept;

  logic [IDX_W-1:0] idx;
  logic [W-1:0]     p_lat, g_lat;
  mlu_carry_mode_t  mode_lat;
  logic             cin_lat;
  logic             carry_reg;
  logic [W-1:0]     carrys_q;
  logic             c_out_q;

  logic [SLICE_W-1:0] p_slice, g_slice, slice_carrys;
  logic               slice_cout;

  // ---------------- FSM ----------------
  always_ff @(posedge CLK) begin
    if (!N_RST) state <= IDLE;
    else        state <= state_nxt;
  end

  // DONE names the output port here, so the state literal is package-qualified.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        BUSY = 1'b1;
        if (idx == LAST_IDX) state_nxt = mlu_pkg::DONE;
      end
      mlu_pkg::DONE: begin
        DONE = 1'b1;
        if (START) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- slice select ----------------
  always_comb begin
    p_slice = '0;
    g_slice = '0;
    for (int unsigned k = 0; k < NUM_SLICES; k++) begin
      if (idx == IDX_W'(k)) begin
        p_slice = p_lat[k*SLICE_W +: SLICE_W];
        g_slice = g_lat[k*SLICE_W +: SLICE_W];
      end
    end
  end

  mlu_slice_carry #(.SLICE_W(SLICE_W)) u_slice (
    .CIN    (carry_reg),
    .P      (p_slice),
    .G      (g_slice),
    .CARRYS (slice_carrys),
    .COUT   (slice_cout)
  );

  // ---------------- datapath ----------------
  always_ff @(posedge CLK) begin
    if (!N_RST) begin
      idx       <= '0;
      p_lat     <= '0;
      g_lat     <= '0;
      mode_lat  <= MLU_CARRY_CHAIN;
      cin_lat   <= 1'b0;
      carry_reg <= 1'b0;
      carrys_q  <= '0;
      c_out_q   <= 1'b0;
    end else if (accept) begin
      p_lat     <= P;
      g_lat     <= G;
      mode_lat  <= mlu_carry_mode_t'(MODE);
      cin_lat   <= C_IN;
      carry_reg <= C_IN;
      idx       <= '0;
    end else if (state == RUN) begin
      for (int unsigned k = 0; k < NUM_SLICES; k++) begin
        if (idx == IDX_W'(k)) carrys_q[k*SLICE_W +: SLICE_W] <= slice_carrys;
      end
      carry_reg <= (mode_lat == MLU_CARRY_LANES) ? cin_lat : slice_cout;
      if (idx == LAST_IDX) c_out_q <= slice_cout;
      else                 idx     <= idx + IDX_W'(1);
    end
  end

  assign CARRYS = carrys_q;
  assign C_OUT  = c_out_q;

  // ---------------- group propagate/generate ----------------
`ifdef MLU_CARRY_GROUP_PG_EN
  logic [NUM_SLICES-1:0] gp_q, gg_q;
  logic [SLICE_W-1:0]    grp_carrys;
  logic                  grp_cout;

  // Same slice recomputed with carry-in 0 gives the slice's own generate.
  mlu_slice_carry #(.SLICE_W(SLICE_W)) u_group (
    .CIN    (1'b0),
    .P      (p_slice),
    .G      (g_slice),
    .CARRYS (grp_carrys),
    .COUT   (grp_cout)
  );

  always_ff @(posedge CLK) begin
    if (!N_RST) begin
      gp_q <= '0;
      gg_q <= '0;
    end else if (state == RUN && !accept) begin
      for (int unsigned k = 0; k < NUM_SLICES; k++) begin
        if (idx == IDX_W'(k)) begin
          gp_q[k] <= &p_slice;
          gg_q[k] <= grp_cout;
        end
      end
    end
  end

  assign GP = gp_q;
  assign GG = gg_q;
`else
  assign GP = '0;
  assign GG = '0;
`endif

  // ---------------- formal reference ----------------
`ifdef FORMAL
  logic [W-1:0] ref_carrys;
  logic         ref_c;

  always_comb begin
    ref_carrys = '0;
    ref_c      = cin_lat;
    for (int unsigned j = 0; j < W; j++) begin
      if (mode_lat == MLU_CARRY_LANES && (j % SLICE_W) == 0) ref_c = cin_lat;
      ref_c         = (ref_c & p_lat[j]) | g_lat[j];
      ref_carrys[j] = ref_c;
    end
  end

  always_ff @(posedge CLK) begin
    if (N_RST && state == mlu_pkg::DONE) begin
      assert (CARRYS == ref_carrys);
    end
  end
`endif

endmodule

// File: tb/tb_mlu_carry_seq.sv
// tb_mlu_carry_seq: self-checking bench for mlu_carry_seq.
// Main instance uses default geometry (8x4); a second instance is 16x1.
module tb_mlu_carry_seq;

`ifdef MLU_CARRY_GROUP_PG_EN
  localparam bit PG_EN = 1'b1;
`else
  localparam bit PG_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] carrys;
    logic        cout;
    logic [3:0]  gp;
    logic [3:0]  gg;
  } exp_t;

  logic        CLK;
  logic        N_RST;
  logic        START, MODE, C_IN;
  logic [31:0] P, G;
  logic [31:0] CARRYS;
  logic        C_OUT, BUSY, DONE;
  logic [3:0]  GP, GG;

  logic        START1, MODE1, C_IN1;
  logic [15:0] P1, G1;
  logic [15:0] CARRYS1;
  logic        C_OUT1, BUSY1, DONE1;
  logic [0:0]  GP1, GG1;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  mlu_carry_seq #(.SLICE_W(8), .NUM_SLICES(4)) dut (
    .CLK(CLK), .N_RST(N_RST), .START(START), .MODE(MODE), .C_IN(C_IN),
    .P(P), .G(G), .CARRYS(CARRYS), .C_OUT(C_OUT), .BUSY(BUSY), .DONE(DONE),
    .GP(GP), .GG(GG)
  );

  mlu_carry_seq #(.SLICE_W(16), .NUM_SLICES(1)) dut1 (
    .CLK(CLK), .N_RST(N_RST), .START(START1), .MODE(MODE1), .C_IN(C_IN1),
    .P(P1), .G(G1), .CARRYS(CARRYS1), .C_OUT(C_OUT1), .BUSY(BUSY1), .DONE(DONE1),
    .GP(GP1), .GG(GG1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic exp_t mk(input logic [31:0] c, input logic co,
                              input logic [3:0] gp, input logic [3:0] gg);
    exp_t r;
    r.carrys = c;
    r.cout   = co;
    r.gp     = PG_EN ? gp : 4'b0000;
    r.gg     = PG_EN ? gg : 4'b0000;
    return r;
  endfunction

  function automatic exp_t model(input logic [31:0] p, input logic [31:0] g,
                                 input logic cin, input logic md);
    exp_t r;
    logic c, c0;
    r.carrys = '0;
    r.gp     = '0;
    r.gg     = '0;
    c = cin;
    for (int i = 0; i < 32; i++) begin
      if (md && (i % 8) == 0) c = cin;
      c = (c & p[i]) | g[i];
      r.carrys[i] = c;
    end
    r.cout = r.carrys[31];
    if (PG_EN) begin
      for (int s = 0; s < 4; s++) begin
        r.gp[s] = &p[s*8 +: 8];
        c0 = 1'b0;
        for (int j = 0; j < 8; j++) c0 = (c0 & p[s*8+j]) | g[s*8+j];
        r.gg[s] = c0;
      end
    end
    return r;
  endfunction

  task automatic test_reset();
    N_RST = 1'b0; START = 1'b0; MODE = 1'b0; C_IN = 1'b0; P = '0; G = '0;
    START1 = 1'b0; MODE1 = 1'b0; C_IN1 = 1'b0; P1 = '0; G1 = '0;
    repeat (2) @(negedge CLK);
    total++; if (CARRYS !== 32'h0) begin bad++; $display("FAIL reset_carrys got=%h exp=0", CARRYS); end
    total++; if (C_OUT !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", C_OUT); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", DONE); end
    total++; if (GP !== 4'h0 || GG !== 4'h0) begin bad++; $display("FAIL reset_gpgg got=%b/%b exp=0/0", GP, GG); end
    total++; if (CARRYS1 !== 16'h0 || DONE1 !== 1'b0) begin bad++; $display("FAIL reset_dut1 got=%h/%b exp=0/0", CARRYS1, DONE1); end
    N_RST = 1'b1;
  endtask

  // Starts at a negedge with the DUT able to accept; ends at a negedge in IDLE.
  task automatic run_op(input string nm, input logic [31:0] p, input logic [31:0] g,
                        input logic cin, input logic md, input exp_t e);
    int   busy_n = 0;
    int   lat    = 0;
    bit   seen   = 1'b0;
    exp_t got;
    P = p; G = g; C_IN = cin; MODE = md; START = 1'b1;
    sb.push_back(e);
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge CLK);
      START = 1'b0;
      P = $urandom; G = $urandom; C_IN = 1'($urandom); MODE = 1'($urandom);
      total++; if (BUSY && DONE) begin bad++; $display("FAIL %s_busy_done_overlap got=1 exp=0", nm); end
      if (BUSY) busy_n++;
      if (DONE) begin
        seen = 1'b1;
        lat  = n;
        got  = sb.pop_front();
        total++; if (CARRYS !== got.carrys) begin bad++; $display("FAIL %s_carrys got=%h exp=%h", nm, CARRYS, got.carrys); end
        total++; if (C_OUT !== got.cout) begin bad++; $display("FAIL %s_cout got=%b exp=%b", nm, C_OUT, got.cout); end
        total++; if (GP !== got.gp) begin bad++; $display("FAIL %s_gp got=%b exp=%b", nm, GP, got.gp); end
        total++; if (GG !== got.gg) begin bad++; $display("FAIL %s_gg got=%b exp=%b", nm, GG, got.gg); end
        total++; if (lat != 5) begin bad++; $display("FAIL %s_latency got=%0d exp=5", nm, lat); end
        total++; if (busy_n != 4) begin bad++; $display("FAIL %s_busy_cycles got=%0d exp=4", nm, busy_n); end
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL %s_timeout got=no_done exp=done", nm);
      sb.delete();
    end
    @(negedge CLK);
    total++; if (DONE !== 1'b0 || CARRYS !== e.carrys || C_OUT !== e.cout) begin
      bad++; $display("FAIL %s_hold got=%b/%h/%b exp=0/%h/%b", nm, DONE, CARRYS, C_OUT, e.carrys, e.cout);
    end
  endtask

  task automatic test_chain();
    run_op("chain_allprop", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, mk(32'hFFFF_FFFF, 1'b1, 4'b1111, 4'b0000));
    run_op("chain_gen", 32'h0000_FF00, 32'h0000_0080, 1'b0, 1'b0, mk(32'h0000_FF80, 1'b0, 4'b0010, 4'b0001));
  endtask

  task automatic test_lanes();
    run_op("lanes_gen", 32'h0000_FF00, 32'h0000_0080, 1'b0, 1'b1, mk(32'h0000_0080, 1'b0, 4'b0010, 4'b0001));
    run_op("lanes_cin", 32'h0101_0101, 32'h0, 1'b1, 1'b1, mk(32'h0101_0101, 1'b0, 4'b0000, 4'b0000));
  endtask

  task automatic test_random();
    logic [31:0] p, g;
    logic        c, m;
    for (int i = 0; i < 6; i++) begin
      p = $urandom; g = $urandom & $urandom; c = 1'($urandom); m = 1'($urandom);
      if (i == 0) g = 32'h0;
      run_op("random", p, g, c, m, model(p, g, c, m));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vp[2];
    logic [31:0] vg[2];
    logic        vc[2];
    exp_t        ve[2];
    exp_t        got;
    int          ops = 1;
    int          last = 0;
    bit          finished = 1'b0;
    vp[0] = 32'hFFFF_FFFF; vg[0] = 32'h0;         vc[0] = 1'b1;
    vp[1] = 32'h0000_FF00; vg[1] = 32'h0000_0080; vc[1] = 1'b0;
    ve[0] = mk(32'hFFFF_FFFF, 1'b1, 4'b1111, 4'b0000);
    ve[1] = mk(32'h0000_FF80, 1'b0, 4'b0010, 4'b0001);
    P = vp[0]; G = vg[0]; C_IN = vc[0]; MODE = 1'b0; START = 1'b1;
    sb.push_back(ve[0]);
    for (int n = 1; n <= 60 && !finished; n++) begin
      @(negedge CLK);
      P = $urandom; G = $urandom; C_IN = 1'($urandom);
      total++; if (BUSY && DONE) begin bad++; $display("FAIL b2b_busy_done_overlap got=1 exp=0"); end
      if (DONE) begin
        total++; if (n - last != 5) begin bad++; $display("FAIL b2b_interval got=%0d exp=5", n - last); end
        last = n;
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL b2b_scoreboard got=empty exp=entry");
        end else begin
          got = sb.pop_front();
          if (CARRYS !== got.carrys || C_OUT !== got.cout) begin
            bad++; $display("FAIL b2b_result got=%h/%b exp=%h/%b", CARRYS, C_OUT, got.carrys, got.cout);
          end
        end
        if (ops < 6) begin
          P = vp[ops % 2]; G = vg[ops % 2]; C_IN = vc[ops % 2];
          sb.push_back(ve[ops % 2]);
          ops++;
        end else begin
          START = 1'b0;
          finished = 1'b1;
        end
      end
    end
    total++;
    if (!finished) begin
      bad++; $display("FAIL b2b_timeout got=%0d_ops exp=6", ops);
      START = 1'b0;
      sb.delete();
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_midrun();
    int pulses = 0;
    P = 32'hFFFF_FFFF; G = 32'h0; C_IN = 1'b1; MODE = 1'b0; START = 1'b1;
    sb.push_back(mk(32'hFFFF_FFFF, 1'b1, 4'b1111, 4'b0000));
    @(negedge CLK);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    N_RST = 1'b0;            // asserted during RUN slice 2
    @(negedge CLK);
    N_RST = 1'b1;
    sb.delete();
    total++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin bad++; $display("FAIL midrst_ctrl got=%b/%b exp=0/0", BUSY, DONE); end
    total++; if (CARRYS !== 32'h0 || C_OUT !== 1'b0) begin bad++; $display("FAIL midrst_data got=%h/%b exp=0/0", CARRYS, C_OUT); end
    total++; if (GP !== 4'h0 || GG !== 4'h0) begin bad++; $display("FAIL midrst_gpgg got=%b/%b exp=0/0", GP, GG); end
    for (int n = 0; n < 8; n++) begin
      @(negedge CLK);
      if (DONE) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", pulses); end
    run_op("after_reset", 32'h0000_FF00, 32'h0000_0080, 1'b0, 1'b0, mk(32'h0000_FF80, 1'b0, 4'b0010, 4'b0001));
  endtask

  task automatic test_single_slice();
    int busy_n = 0;
    bit seen   = 1'b0;
    P1 = 16'hFFFF; G1 = 16'h0; C_IN1 = 1'b1; MODE1 = 1'b0; START1 = 1'b1;
    for (int n = 1; n <= 10 && !seen; n++) begin
      @(negedge CLK);
      START1 = 1'b0; P1 = 16'($urandom); G1 = 16'($urandom);
      if (BUSY1) busy_n++;
      if (DONE1) begin
        seen = 1'b1;
        total++; if (n != 2) begin bad++; $display("FAIL single_latency got=%0d exp=2", n); end
        total++; if (busy_n != 1) begin bad++; $display("FAIL single_busy got=%0d exp=1", busy_n); end
        total++; if (CARRYS1 !== 16'hFFFF || C_OUT1 !== 1'b1) begin
          bad++; $display("FAIL single_result got=%h/%b exp=ffff/1", CARRYS1, C_OUT1);
        end
        total++; if (GP1 !== 1'(PG_EN) || GG1 !== 1'b0) begin
          bad++; $display("FAIL single_gpgg got=%b/%b exp=%b/0", GP1, GG1, PG_EN);
        end
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL single_timeout got=no_done exp=done"); end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_chain();
    test_lanes();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    test_single_slice();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mlu_carry_seq.md
# mlu_carry_seq

Parametrised, multi-cycle carry engine for the MLU. It resolves carries over a `SLICE_W*NUM_SLICES`-bit propagate/generate word, one slice per clock, with a registered inter-slice carry. Mode select: one wide ripple chain, or independent SIMD lanes that each take `C_IN`. It sits between the MLU P/G generation stage and the sum stage, and supports operand widths beyond the single-cycle 8-bit lookahead.

## Interface
Parameters:
- `SLICE_W`, 8: bits resolved per cycle.
- `NUM_SLICES`, 4: slices per operation; total width `W = SLICE_W*NUM_SLICES`.

Ports:
- `CLK` in 1: single clock; all state on rising edge.
- `N_RST` in 1: synchronous, active-low reset.
- `START` in 1: request; sampled only when accepting (state IDLE or DONE).
- `MODE` in 1: 0 = CHAIN (carry ripples across slices), 1 = LANES (every slice starts from `C_IN`).
- `C_IN` in 1: carry into bit 0 (CHAIN) or into every slice (LANES).
- `P` in W: per-bit propagate.
- `G` in W: per-bit generate.
- `CARRYS` out W: `CARRYS[i]` = carry out of bit i.
- `C_OUT` out 1: `CARRYS[W-1]`, registered with the result.
- `BUSY` out 1: high in RUN.
- `DONE` out 1: one-cycle pulse; `CARRYS`/`C_OUT` valid and held until next accepted `START`.
- `GP` out NUM_SLICES: per-slice group propagate (see Configuration).
- `GG` out NUM_SLICES: per-slice group generate (see Configuration).

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `START`=1 latches `P`, `G`, `MODE`, `C_IN`; slice index := 0; carry reg := `C_IN`. Next state is RUN.
- RUN, each cycle, for slice k:
  - ripple `c = (c_prev & P[j]) | G[j]` over bits `k*SLICE_W .. k*SLICE_W+SLICE_W-1`, starting from the carry reg;
  - write the results into `CARRYS` slice k;
  - carry reg := slice carry-out (CHAIN) or latched `C_IN` (LANES).
- RUN, k = NUM_SLICES-1: `C_OUT` := top-bit carry; next state is DONE. Otherwise k increments.
- DONE: `DONE`=1 for exactly one cycle. Next state is IDLE, or RUN if `START`=1 (back-to-back accept, same latching as IDLE).
- `START` during RUN is ignored; no queuing.
- Inputs are latched at accept, so `P`/`G` may change freely afterwards.
- Slice index width is `$clog2(NUM_SLICES)` (min 1). NUM_SLICES=1 is legal: RUN lasts one cycle.
- Reset, including mid-operation: state IDLE; `CARRYS`=0, `C_OUT`=0, `BUSY`=0, `DONE`=0, `GP`=0, `GG`=0, carry reg=0, index=0.

## Timing
- Accept edge t0 → RUN occupies cycles t0+1..t0+NUM_SLICES → `DONE` high in cycle t0+NUM_SLICES+1.
- Latency from accept to `DONE` = NUM_SLICES+1 cycles.
- Throughput: one operation per NUM_SLICES+1 cycles with back-to-back `START`.
- `CARRYS` slices below k update during RUN. Consumers use `CARRYS` only when `DONE`=1 or after it.
- `BUSY` and `DONE` are never high together.

## Configuration
- `MLU_CARRY_GROUP_PG_EN` defined:
  - during each slice's RUN cycle, register `GP[k]` = AND of that slice's latched `P`;
  - register `GG[k]` = that slice's carry-out computed with carry-in 0;
  - both are valid at `DONE`, for the upper-level lookahead.
- Not defined: `GP` and `GG` are tied to 0, and no extra logic or registers are generated. The ports remain, so the interface is stable.

## Structure
- Shared `mlu_pkg`:
  - state enum `mlu_carry_state_t` {IDLE, RUN, DONE};
  - mode enum `mlu_carry_mode_t` {MLU_CARRY_CHAIN=0, MLU_CARRY_LANES=1};
  - defaults `MLU_SLICE_W_DEFAULT`=8 and `MLU_NUM_SLICES_DEFAULT`=4.
- One combinational sub-module, `mlu_slice_carry`:
  - parameter `SLICE_W`; inputs `CIN`, `P`, `G`;
  - outputs `CARRYS[SLICE_W]` and `COUT`;
  - instantiated once on the muxed slice, and a second time with `CIN`=0 for `GG` under `MLU_CARRY_GROUP_PG_EN`.
- FSM, index counter, latches and output registers live in `mlu_carry_seq`.
- Under `FORMAL`: assert at `DONE` that `CARRYS` equals a full-width combinational ripple reference for the latched mode.

## Test plan
Defaults: SLICE_W=8, NUM_SLICES=4.
1. CHAIN, `P`=0xFFFFFFFF, `G`=0, `C_IN`=1 → at `DONE`, `CARRYS`=0xFFFFFFFF, `C_OUT`=1; `DONE` exactly 5 cycles after the accept edge; `BUSY` high 4 cycles.
2. CHAIN, `P`=0x0000FF00, `G`=0x00000080, `C_IN`=0 → `CARRYS`=0x0000FF80, `C_OUT`=0; with the macro, `GP`=4'b0010, `GG`=4'b0001 (without the macro, both 0).
3. Same inputs, LANES → `CARRYS`=0x00000080, `C_OUT`=0. Then LANES, `P`=0x01010101, `G`=0, `C_IN`=1 → `CARRYS`=0x01010101.
4. `START` held high continuously with alternating vectors from scenarios 1 and 2 → `DONE` every 5 cycles, results correct per operation, `START` ignored during RUN. Inputs changed mid-RUN do not affect the result.
5. `N_RST`=0 for one cycle during RUN slice 2 → next cycle: IDLE, all outputs 0, no `DONE` pulse. A subsequent `START` completes normally.
6. NUM_SLICES=1, SLICE_W=16 build: `P`=0xFFFF, `G`=0, `C_IN`=1 → `DONE` 2 cycles after accept, `CARRYS`=0xFFFF, `C_OUT`=1.
